ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath width of ALU result, store data and branch target.
REQ-002 SHALL have parameter REG_AW, default 5, width of destination register index.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 ex_valid  input  1  EX stage holds a real instruction (0 = bubble).
REQ-007 alu_result  input  DATA_W  ALU output for the EX instruction.
REQ-008 alu_zero  input  1  ALU zero flag for the EX instruction.
REQ-009 ex_store_data  input  DATA_W  rs2 value for stores.
REQ-010 ex_branch_target  input  DATA_W  precomputed PC + offset.
REQ-011 ex_rd  input  REG_AW  destination register index.
REQ-012 ex_ctrl  input  5  {branch, mem_read, mem_write, reg_write, mem_to_reg}, MSB first.
REQ-013 stall  input  1  hold all stage registers.
REQ-014 flush  input  1  replace the captured instruction with a bubble.
REQ-015 mem_valid, mem_alu_result, mem_store_data, mem_rd, mem_ctrl  output  1/DATA_W/DATA_W/REG_AW/5  registered copies of the EX fields.
REQ-016 pc_redirect  output  1  taken-branch request to PC select.
REQ-017 redirect_target  output  DATA_W  PC to load when pc_redirect = 1.
REQ-018 fwd_en, fwd_rd, fwd_data  output  1/REG_AW/DATA_W  EX-to-EX forwarding source.
REQ-019 redirect_count  output  8  saturating count of taken branches.

Function
REQ-020 Each rising edge SHALL perform exactly one of, in priority order: flush, stall, squash, capture.
REQ-021 Flush (flush = 1, regardless of stall) SHALL load mem_valid = 0 and mem_ctrl = 0; other data fields are don't-care.
REQ-022 Stall (stall = 1, flush = 0) SHALL hold every stage register and redirect_count unchanged.
REQ-023 Squash (pc_redirect = 1, stall = 0, flush = 0) SHALL load a bubble identical to flush, dropping the wrong-path EX instruction.
REQ-024 Capture SHALL load mem_valid = ex_valid, mem_ctrl = ex_valid ? ex_ctrl : 0, and all data fields from their EX inputs; latency EX -> MEM exactly one cycle.
REQ-025 The stage SHALL register alu_zero and ex_branch_target alongside the other fields.
REQ-026 pc_redirect SHALL equal mem_valid & mem_ctrl[4] & registered zero, combinational from stage registers only; redirect_target SHALL equal the registered branch target.
REQ-027 pc_redirect SHALL remain asserted through a stall; repeated assertion is idempotent for the PC.
REQ-028 fwd_en SHALL equal mem_valid & reg_write & !mem_read & (mem_rd != 0); fwd_rd = mem_rd; fwd_data = mem_alu_result.
REQ-029 redirect_count SHALL increment by 1 on each edge where pc_redirect = 1 and stall = 0 (flush does not block the count), saturating at 255 with no wrap.
REQ-030 Arithmetic is not performed on data fields; widths pass through unchanged.

Reset
REQ-031 rst_n = 0 SHALL immediately, without a clock, force mem_valid = 0, mem_ctrl = 0, all data fields = 0, redirect_count = 0, so pc_redirect = 0 and fwd_en = 0.
REQ-032 Reset asserted mid-stall or mid-redirect SHALL override all other inputs; first capture occurs on the first rising edge with rst_n = 1.

Verification
REQ-033 Capture: ex_valid=1, alu_result=0x5A, ex_rd=3, ex_ctrl=00010 -> next cycle mem_valid=1, mem_alu_result=0x5A, fwd_en=1, fwd_rd=3, fwd_data=0x5A.
REQ-034 Taken branch: ex_ctrl=10000, alu_zero=1, target=0x40 -> next cycle pc_redirect=1, redirect_target=0x40; following edge squashes (mem_valid=0), redirect_count=1.
REQ-035 Stall/flush priority: stall=1 for 3 cycles holds outputs; stall=1 with flush=1 -> bubble next cycle.
REQ-036 Forward suppression: load (ctrl=01011) or rd=0 with reg_write -> fwd_en=0.
REQ-037 Saturation: 260 taken branches -> redirect_count=255.
REQ-038 Async reset: rst_n low between clock edges -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures the executed instruction, resolves taken
// branches into a PC redirect, squashes the wrong-path instruction behind a
// taken branch, and exposes the MEM-stage result as an EX-to-EX forward source.
module ex_mem_stage #(
    parameter  int unsigned DATA_W = 8,
    parameter  int unsigned REG_AW = 5,
    localparam int unsigned CTRL_W = 5,
    localparam int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [CTRL_W-1:0] ex_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              mem_valid,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_AW-1:0] mem_rd,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              pc_redirect,
    output logic [DATA_W-1:0] redirect_target,
    output logic              fwd_en,
    output logic [REG_AW-1:0] fwd_rd,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  redirect_count
);

    // Control vector bit positions: {branch, mem_read, mem_write, reg_write, mem_to_reg}
    localparam int unsigned C_BRANCH    = 4;
    localparam int unsigned C_MEM_READ  = 3;
    localparam int unsigned C_REG_WRITE = 1;

    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_STALL   = 2'd1,
        ACT_SQUASH  = 2'd2,
        ACT_FLUSH   = 2'd3
    } action_t;

    action_t           action_c;
    logic              mem_zero;
    logic [DATA_W-1:0] mem_branch_target;

    // Select the single action for this edge: flush > stall > squash > capture
    always_comb begin
        action_c = ACT_CAPTURE;
        if (flush) begin
            action_c = ACT_FLUSH;
        end else if (stall) begin
            action_c = ACT_STALL;
        end else if (pc_redirect) begin
            action_c = ACT_SQUASH;
        end
    end

    // Valid/control registers; flush and squash both insert a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid <= 1'b0;
            mem_ctrl  <= '0;
        end else begin
            case (action_c)
                ACT_FLUSH, ACT_SQUASH: begin
                    mem_valid <= 1'b0;
                    mem_ctrl  <= '0;
                end
                ACT_CAPTURE: begin
                    mem_valid <= ex_valid;
                    mem_ctrl  <= ex_valid ? ex_ctrl : '0;
                end
                default: begin
                    mem_valid <= mem_valid;
                    mem_ctrl  <= mem_ctrl;
                end
            endcase
        end
    end

    // Data fields load only on capture; in a bubble their contents are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_alu_result    <= '0;
            mem_store_data    <= '0;
            mem_rd            <= '0;
            mem_zero          <= 1'b0;
            mem_branch_target <= '0;
        end else if (action_c == ACT_CAPTURE) begin
            mem_alu_result    <= alu_result;
            mem_store_data    <= ex_store_data;
            mem_rd            <= ex_rd;
            mem_zero          <= alu_zero;
            mem_branch_target <= ex_branch_target;
        end
    end

    // Saturating count of taken branches that leave the stage (flush still counts)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_count <= '0;
        end else if (pc_redirect && !stall && (redirect_count != '1)) begin
            redirect_count <= redirect_count + CNT_W'(1);
        end
    end

    // Branch resolution and forwarding, decoded from stage registers only
    always_comb begin
        pc_redirect     = mem_valid & mem_ctrl[C_BRANCH] & mem_zero;
        redirect_target = mem_branch_target;
        fwd_en          = mem_valid & mem_ctrl[C_REG_WRITE] & ~mem_ctrl[C_MEM_READ]
                          & (mem_rd != '0);
        fwd_rd          = mem_rd;
        fwd_data        = mem_alu_result;
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed vector table, hand-written multi-cycle
// sequences (stall hold, async reset, counter saturation) and random stimulus
// against a behavioural model of the stage contents.
module tb_ex_mem_stage;

    logic       clk;
    logic       rst_n;
    logic       ex_valid;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic [7:0] ex_store_data;
    logic [7:0] ex_branch_target;
    logic [4:0] ex_rd;
    logic [4:0] ex_ctrl;
    logic       stall;
    logic       flush;
    logic       mem_valid;
    logic [7:0] mem_alu_result;
    logic [7:0] mem_store_data;
    logic [4:0] mem_rd;
    logic [4:0] mem_ctrl;
    logic       pc_redirect;
    logic [7:0] redirect_target;
    logic       fwd_en;
    logic [4:0] fwd_rd;
    logic [7:0] fwd_data;
    logic [7:0] redirect_count;

    int n_cmp;
    int n_err;

    ex_mem_stage #(.DATA_W(8), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .alu_result(alu_result),
        .alu_zero(alu_zero), .ex_store_data(ex_store_data),
        .ex_branch_target(ex_branch_target), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .stall(stall), .flush(flush), .mem_valid(mem_valid),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data),
        .mem_rd(mem_rd), .mem_ctrl(mem_ctrl), .pc_redirect(pc_redirect),
        .redirect_target(redirect_target), .fwd_en(fwd_en), .fwd_rd(fwd_rd),
        .fwd_data(fwd_data), .redirect_count(redirect_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of the MEM stage as the bench understands them
    typedef struct {
        bit       valid;
        bit [4:0] ctrl;
        bit [7:0] alu;
        bit [7:0] sd;
        bit [7:0] tgt;
        bit       zero;
        bit [4:0] rd;
        int       cnt;
    } model_t;
    model_t m;

    typedef struct {
        bit       flush;
        bit       stall;
        bit       v;
        bit [4:0] ctrl;
        bit [7:0] alu;
        bit [7:0] sd;
        bit [7:0] tgt;
        bit       zero;
        bit [4:0] rd;
        bit       e_valid;
        bit [4:0] e_ctrl;
        bit [7:0] e_alu;
        bit [4:0] e_rd;
        bit       e_redir;
        bit [7:0] e_tgt;
        bit       e_fwd;
        bit [7:0] e_cnt;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_redirect();
        return m.valid && m.ctrl[4] && m.zero;
    endfunction

    function automatic bit m_fwd();
        return m.valid && m.ctrl[1] && !m.ctrl[3] && (m.rd != 5'd0);
    endfunction

    function automatic void m_reset();
        m = '{valid: 1'b0, ctrl: 5'd0, alu: 8'd0, sd: 8'd0, tgt: 8'd0,
              zero: 1'b0, rd: 5'd0, cnt: 0};
    endfunction

    // One clock edge of the stage rules applied to the model
    function automatic void m_step();
        bit taken;
        taken = m_redirect();
        if (!rst_n) begin
            m_reset();
            return;
        end
        if (taken && !stall && m.cnt < 255) m.cnt = m.cnt + 1;
        if (flush || (taken && !stall)) begin
            m.valid = 1'b0;
            m.ctrl  = 5'd0;
        end else if (!stall) begin
            m.valid = ex_valid;
            m.ctrl  = ex_valid ? ex_ctrl : 5'd0;
            m.alu   = alu_result;
            m.sd    = ex_store_data;
            m.tgt   = ex_branch_target;
            m.zero  = alu_zero;
            m.rd    = ex_rd;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(mem_valid), 32'(m.valid));
        chk({tag, ".ctrl"}, 32'(mem_ctrl), 32'(m.ctrl));
        if (m.valid) begin
            chk({tag, ".alu"}, 32'(mem_alu_result), 32'(m.alu));
            chk({tag, ".sd"}, 32'(mem_store_data), 32'(m.sd));
            chk({tag, ".rd"}, 32'(mem_rd), 32'(m.rd));
        end
        chk({tag, ".redir"}, 32'(pc_redirect), 32'(m_redirect()));
        if (m_redirect()) chk({tag, ".tgt"}, 32'(redirect_target), 32'(m.tgt));
        chk({tag, ".fwd_en"}, 32'(fwd_en), 32'(m_fwd()));
        if (m_fwd()) begin
            chk({tag, ".fwd_rd"}, 32'(fwd_rd), 32'(m.rd));
            chk({tag, ".fwd_data"}, 32'(fwd_data), 32'(m.alu));
        end
        chk({tag, ".cnt"}, 32'(redirect_count), 32'(m.cnt));
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".valid"}, 32'(mem_valid), 32'd0);
        chk({tag, ".ctrl"}, 32'(mem_ctrl), 32'd0);
        chk({tag, ".alu"}, 32'(mem_alu_result), 32'd0);
        chk({tag, ".sd"}, 32'(mem_store_data), 32'd0);
        chk({tag, ".rd"}, 32'(mem_rd), 32'd0);
        chk({tag, ".redir"}, 32'(pc_redirect), 32'd0);
        chk({tag, ".tgt"}, 32'(redirect_target), 32'd0);
        chk({tag, ".fwd_en"}, 32'(fwd_en), 32'd0);
        chk({tag, ".cnt"}, 32'(redirect_count), 32'd0);
    endtask

    task automatic drive(input bit fl, input bit st, input bit v, input bit [4:0] c,
                         input bit [7:0] a, input bit [7:0] s, input bit [7:0] t,
                         input bit z, input bit [4:0] r);
        flush = fl; stall = st; ex_valid = v; ex_ctrl = c; alu_result = a;
        ex_store_data = s; ex_branch_target = t; alu_zero = z; ex_rd = r;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        m_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 8'd0, 8'd0, 8'd0, 1'b0, 5'd0);

        // flush stall v ctrl alu sd tgt zero rd | valid ctrl alu rd redir tgt fwd cnt
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 5'b00010, 8'h5A, 8'h00, 8'h00, 1'b0, 5'd3,
                    1'b1, 5'b00010, 8'h5A, 5'd3, 1'b0, 8'h00, 1'b1, 8'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 5'b01011, 8'h11, 8'h00, 8'h00, 1'b0, 5'd4,
                    1'b1, 5'b01011, 8'h11, 5'd4, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 5'b00010, 8'h22, 8'h00, 8'h00, 1'b0, 5'd0,
                    1'b1, 5'b00010, 8'h22, 5'd0, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 5'b00010, 8'h33, 8'h00, 8'h00, 1'b0, 5'd5,
                    1'b0, 5'b00000, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 8'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 5'b10000, 8'h00, 8'h00, 8'h40, 1'b1, 5'd0,
                    1'b1, 5'b10000, 8'h00, 5'd0, 1'b1, 8'h40, 1'b0, 8'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 5'b00010, 8'h77, 8'h00, 8'h00, 1'b0, 5'd6,
                    1'b0, 5'b00000, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 5'b10000, 8'h01, 8'h00, 8'h80, 1'b0, 5'd0,
                    1'b1, 5'b10000, 8'h01, 5'd0, 1'b0, 8'h00, 1'b0, 8'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 5'b00010, 8'h33, 8'h00, 8'h00, 1'b0, 5'd7,
                    1'b1, 5'b00010, 8'h33, 5'd7, 1'b0, 8'h00, 1'b1, 8'd1};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 5'b01011, 8'h99, 8'h00, 8'h00, 1'b0, 5'd9,
                    1'b1, 5'b00010, 8'h33, 5'd7, 1'b0, 8'h00, 1'b1, 8'd1};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 5'b00010, 8'h55, 8'h00, 8'h00, 1'b0, 5'd8,
                    1'b0, 5'b00000, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 8'd1};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 5'b10000, 8'h02, 8'h00, 8'h44, 1'b1, 5'd0,
                    1'b1, 5'b10000, 8'h02, 5'd0, 1'b1, 8'h44, 1'b0, 8'd1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 5'b00010, 8'h66, 8'h00, 8'h00, 1'b0, 5'd3,
                    1'b0, 5'b00000, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 8'd2};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 5'b00100, 8'h10, 8'hAB, 8'h00, 1'b0, 5'd2,
                    1'b1, 5'b00100, 8'h10, 5'd2, 1'b0, 8'h00, 1'b0, 8'd2};

        // Reset state, observed before any clock edge
        #2;
        check_all_zero("reset0");
        tick();
        #2;
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].flush, tbl[i].stall, tbl[i].v, tbl[i].ctrl, tbl[i].alu,
                  tbl[i].sd, tbl[i].tgt, tbl[i].zero, tbl[i].rd);
            tick();
            chk($sformatf("vec%0d.valid", i), 32'(mem_valid), 32'(tbl[i].e_valid));
            chk($sformatf("vec%0d.ctrl", i), 32'(mem_ctrl), 32'(tbl[i].e_ctrl));
            if (tbl[i].e_valid) begin
                chk($sformatf("vec%0d.alu", i), 32'(mem_alu_result), 32'(tbl[i].e_alu));
                chk($sformatf("vec%0d.rd", i), 32'(mem_rd), 32'(tbl[i].e_rd));
            end
            chk($sformatf("vec%0d.redir", i), 32'(pc_redirect), 32'(tbl[i].e_redir));
            if (tbl[i].e_redir)
                chk($sformatf("vec%0d.tgt", i), 32'(redirect_target), 32'(tbl[i].e_tgt));
            chk($sformatf("vec%0d.fwd_en", i), 32'(fwd_en), 32'(tbl[i].e_fwd));
            if (tbl[i].e_fwd) begin
                chk($sformatf("vec%0d.fwd_rd", i), 32'(fwd_rd), 32'(tbl[i].e_rd));
                chk($sformatf("vec%0d.fwd_data", i), 32'(fwd_data), 32'(tbl[i].e_alu));
            end
            chk($sformatf("vec%0d.cnt", i), 32'(redirect_count), 32'(tbl[i].e_cnt));
            check_model($sformatf("vec%0d.model", i));
        end
        chk("vec12.sd", 32'(mem_store_data), 32'hAB);

        // Redirect held through a 3-cycle stall; count does not move
        drive(1'b0, 1'b0, 1'b1, 5'b10000, 8'h00, 8'h00, 8'h5C, 1'b1, 5'd0);
        tick();
        chk("brstall.redir0", 32'(pc_redirect), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, 5'b00010, 8'(i + 1), 8'h00, 8'h00, 1'b0, 5'd9);
            tick();
            chk($sformatf("brstall%0d.redir", i), 32'(pc_redirect), 32'd1);
            chk($sformatf("brstall%0d.tgt", i), 32'(redirect_target), 32'h5C);
            chk($sformatf("brstall%0d.cnt", i), 32'(redirect_count), 32'd2);
            chk($sformatf("brstall%0d.valid", i), 32'(mem_valid), 32'd1);
        end

        // Asynchronous reset between edges, mid-stall with a redirect pending
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("areset");
        m_reset();
        tick();
        check_all_zero("areset_hold");
        #2;
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'b00010, 8'h5A, 8'h00, 8'h00, 1'b0, 5'd3);
        tick();
        chk("post_rst.valid", 32'(mem_valid), 32'd1);
        chk("post_rst.fwd_en", 32'(fwd_en), 32'd1);
        chk("post_rst.fwd_rd", 32'(fwd_rd), 32'd3);
        chk("post_rst.fwd_data", 32'(fwd_data), 32'h5A);

        // 260 taken branches (each captured then squashed) saturate the counter
        drive(1'b0, 1'b0, 1'b1, 5'b10000, 8'h00, 8'h00, 8'h20, 1'b1, 5'd0);
        tick();
        for (int i = 0; i < 520; i++) begin
            tick();
            check_model("sat");
        end
        chk("sat.cnt255", 32'(redirect_count), 32'd255);
        for (int i = 0; i < 4; i++) tick();
        chk("sat.cnt_hold", 32'(redirect_count), 32'd255);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                  1'($urandom), 5'($urandom), 8'($urandom), 8'($urandom),
                  8'($urandom), ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)));
            tick();
            check_model("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
